// File: rtl/imsic_pkg.sv
// Shared constants, types and helpers for the bus-MSI front end of the IMSIC.
// Field widths of imsic_msi_t match the default two-hart, 64-identity, single-VS configuration.
package imsic_pkg;

    localparam int IMSIC_PAGE_W = 12;

    localparam logic [IMSIC_PAGE_W-1:0] SETEIPNUM_LE_OFF = 12'h000;
    localparam logic [IMSIC_PAGE_W-1:0] SETEIPNUM_BE_OFF = 12'h004;

    localparam int IMSIC_SETIPNUM_W = 6;
    localparam int IMSIC_NR_HARTS   = 2;
    localparam int IMSIC_FILE_SEL_W = 2;

    typedef struct packed {
        logic [IMSIC_SETIPNUM_W-1:0] setipnum;
        logic [IMSIC_NR_HARTS-1:0]   imsic_en;
        logic [IMSIC_FILE_SEL_W-1:0] select_file;
    } imsic_msi_t;

    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/imsic_msi_fifo.sv
// Synchronous FIFO for decoded MSIs; the head entry is driven straight from storage flops,
// so an entry pushed in one cycle is visible at the head in the next.
module imsic_msi_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             ni_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign o_full  = (cnt_q == CNT_W'(DEPTH));
    assign o_empty = (cnt_q == '0);
    assign do_push = i_push & ~o_full;
    assign do_pop  = i_pop & ~o_empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        // Pointer width equals log2(DEPTH), so the increment wraps modulo DEPTH by itself.
        if (do_push) wptr_d = wptr_q + PTR_W'(1);
        if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!ni_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wptr_q] <= i_data;
    end

    // Empty reads as zero so stale storage never reaches the IMSIC fields.
    assign o_head = o_empty ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/imsic_msi_decoder.sv
// Decodes single-beat MSI writes into IMSIC setipnum/imsic_en/select_file triples,
// discarding malformed writes and counting them in a saturating drop counter.
module imsic_msi_decoder
    import imsic_pkg::*;
#(
    parameter int          NrHarts        = 2,
    parameter int          NrSources      = 64,
    parameter int          NrSourcesW     = 6,
    parameter int          NrVSInptFiles  = 1,
    parameter int          NrInptFilesW   = 2,
    parameter logic [31:0] InptFilesMAddr = 32'h24000000,
    parameter logic [31:0] InptFilesSAddr = 32'h28000000,
    parameter int          FifoDepth      = 4
) (
    input  logic                    i_clk,
    input  logic                    ni_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [31:0]             i_req_addr,
    input  logic [31:0]             i_req_data,
    output logic                    o_msi_valid,
    input  logic                    i_msi_ready,
    output logic [NrSourcesW-1:0]   o_setipnum,
    output logic [NrHarts-1:0]      o_imsic_en,
    output logic [NrInptFilesW-1:0] o_select_file,
    output logic [15:0]             o_drop_cnt
);

    localparam int          FilesPerHart = NrVSInptFiles + 1;
    localparam logic [31:0] MWinSize     = 32'(NrHarts) << IMSIC_PAGE_W;
    localparam logic [31:0] SWinSize     = 32'(NrHarts * FilesPerHart) << IMSIC_PAGE_W;
    localparam int          EntryW       = NrSourcesW + NrHarts + NrInptFilesW;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [31:0]             off_m, off_s;
    logic [31:0]             page_m, page_s;
    logic                    in_m, in_s;
    logic [31:0]             hart_idx, file_idx;
    logic [31:0]             ident;
    logic [IMSIC_PAGE_W-1:0] page_off;
    logic                    off_le, off_be;
    logic                    msi_ok;
    logic [NrHarts-1:0]      en_dec;
    logic [EntryW-1:0]       entry, head;

    logic        rdy_q;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        fifo_full, fifo_empty;
    logic        accept, push, drop;

    always_comb begin
        off_m    = i_req_addr - InptFilesMAddr;
        off_s    = i_req_addr - InptFilesSAddr;
        in_m     = (i_req_addr >= InptFilesMAddr) && (off_m < MWinSize);
        in_s     = (i_req_addr >= InptFilesSAddr) && (off_s < SWinSize);
        page_m   = off_m >> IMSIC_PAGE_W;
        page_s   = off_s >> IMSIC_PAGE_W;
        page_off = i_req_addr[IMSIC_PAGE_W-1:0];
        off_le   = (page_off == SETEIPNUM_LE_OFF);
        off_be   = (page_off == SETEIPNUM_BE_OFF);

        hart_idx = '0;
        file_idx = '0;
        if (in_m) begin
            hart_idx = page_m;
        end else if (in_s) begin
            // Constant divisor: collapses to shift/mask when FilesPerHart is a power of two.
            hart_idx = page_s / 32'(FilesPerHart);
            file_idx = 32'd1 + (page_s % 32'(FilesPerHart));
        end

        ident  = off_be ? bswap32(i_req_data) : i_req_data;
        msi_ok = (in_m | in_s) & (off_le | off_be)
               & (ident != 32'd0) & (ident < 32'(NrSources));

        en_dec = '0;
        for (int h = 0; h < NrHarts; h++) begin
            en_dec[h] = (hart_idx == 32'(h));
        end

        entry = {ident[NrSourcesW-1:0], en_dec, file_idx[NrInptFilesW-1:0]};
    end

    assign o_req_ready = rdy_q & ~fifo_full;
    assign accept      = i_req_valid & o_req_ready;
    assign push        = accept & msi_ok;
    assign drop        = accept & ~msi_ok;
    assign drop_cnt_d  = drop ? sat_inc16(drop_cnt_q) : drop_cnt_q;

    // Ready is held low through reset and rises on the first clock after release.
    always_ff @(posedge i_clk) begin
        if (!ni_rst) begin
            rdy_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            rdy_q      <= 1'b1;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    imsic_msi_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FifoDepth)
    ) u_fifo (
        .i_clk   (i_clk),
        .ni_rst  (ni_rst),
        .i_push  (push),
        .i_data  (entry),
        .i_pop   (i_msi_ready),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_head  (head)
    );

    assign o_msi_valid = ~fifo_empty;
    assign {o_setipnum, o_imsic_en, o_select_file} = head;
    assign o_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_imsic_msi_decoder.sv
// Directed-vector bench for imsic_msi_decoder with hand-computed expectations.
module tb_imsic_msi_decoder;

    logic        i_clk;
    logic        ni_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_data;
    logic        o_msi_valid;
    logic        i_msi_ready;
    logic [5:0]  o_setipnum;
    logic [1:0]  o_imsic_en;
    logic [1:0]  o_select_file;
    logic [15:0] o_drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    imsic_msi_decoder dut (
        .i_clk         (i_clk),
        .ni_rst        (ni_rst),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_addr    (i_req_addr),
        .i_req_data    (i_req_data),
        .o_msi_valid   (o_msi_valid),
        .i_msi_ready   (i_msi_ready),
        .o_setipnum    (o_setipnum),
        .o_imsic_en    (o_imsic_en),
        .o_select_file (o_select_file),
        .o_drop_cnt    (o_drop_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d);
        i_req_valid = 1'b1;
        i_req_addr  = a;
        i_req_data  = d;
    endtask

    task automatic idle();
        i_req_valid = 1'b0;
        i_req_addr  = '0;
        i_req_data  = '0;
    endtask

    task automatic check_msi(input string tag, input logic [5:0] id,
                             input logic [1:0] en, input logic [1:0] file);
        check({tag, "_vld"},  32'(o_msi_valid),   32'd1);
        check({tag, "_id"},   32'(o_setipnum),    32'(id));
        check({tag, "_en"},   32'(o_imsic_en),    32'(en));
        check({tag, "_file"}, 32'(o_select_file), 32'(file));
    endtask

    logic [31:0] drop_addr [5];
    logic [31:0] drop_data [5];

    initial begin
        drop_addr[0] = 32'h24000000; drop_data[0] = 32'd0;
        drop_addr[1] = 32'h24000000; drop_data[1] = 32'd64;
        drop_addr[2] = 32'h24002000; drop_data[2] = 32'd3;
        drop_addr[3] = 32'h28000008; drop_data[3] = 32'd3;
        drop_addr[4] = 32'h28004000; drop_data[4] = 32'd3;

        ni_rst      = 1'b0;
        i_msi_ready = 1'b0;
        idle();
        tick();
        tick();
        check("rst_vld",   32'(o_msi_valid),   32'd0);
        check("rst_id",    32'(o_setipnum),    32'd0);
        check("rst_en",    32'(o_imsic_en),    32'd0);
        check("rst_file",  32'(o_select_file), 32'd0);
        check("rst_drop",  32'(o_drop_cnt),    32'd0);
        check("rst_ready", 32'(o_req_ready),   32'd0);
        ni_rst = 1'b1;
        tick();
        check("post_rst_ready", 32'(o_req_ready), 32'd1);

        // M file of hart 1, little-endian identity
        i_msi_ready = 1'b1;
        req(32'h24001000, 32'd5);
        tick();
        idle();
        check_msi("m_h1", 6'd5, 2'b10, 2'd0);
        tick();
        check("m_h1_drained", 32'(o_msi_valid), 32'd0);

        // S file of hart 0
        req(32'h28000000, 32'd9);
        tick();
        idle();
        check_msi("s_h0", 6'd9, 2'b01, 2'd1);
        tick();

        // VS1 of hart 1 via the big-endian offset
        req(32'h28003004, 32'h07000000);
        tick();
        idle();
        check_msi("vs_h1_be", 6'd7, 2'b10, 2'd2);
        tick();
        check("vs_h1_drained", 32'(o_msi_valid), 32'd0);

        // Identity 0, identity 64, outside M window, bad offset, outside S window
        for (int i = 0; i < 5; i++) begin
            req(drop_addr[i], drop_data[i]);
            tick();
            check($sformatf("drop%0d_vld", i), 32'(o_msi_valid), 32'd0);
        end
        idle();
        check("drop_cnt", 32'(o_drop_cnt), 32'd5);

        // Back-pressure: four fill the FIFO, the fifth waits
        i_msi_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            req(32'h24000000, 32'(k));
            check($sformatf("bp_ready%0d", k), 32'(o_req_ready), (k <= 4) ? 32'd1 : 32'd0);
            tick();
        end
        check("bp_full_ready", 32'(o_req_ready), 32'd0);
        check_msi("bp_head1", 6'd1, 2'b01, 2'd0);
        i_msi_ready = 1'b1;
        tick();
        check_msi("bp_head2", 6'd2, 2'b01, 2'd0);
        check("bp_ready_after_pop", 32'(o_req_ready), 32'd1);
        tick();
        idle();
        check_msi("bp_head3", 6'd3, 2'b01, 2'd0);
        tick();
        check_msi("bp_head4", 6'd4, 2'b01, 2'd0);
        tick();
        check_msi("bp_head5", 6'd5, 2'b01, 2'd0);
        tick();
        check("bp_empty", 32'(o_msi_valid), 32'd0);
        check("bp_drop_cnt", 32'(o_drop_cnt), 32'd5);

        // Occupancy 3 with simultaneous push and pop
        i_msi_ready = 1'b0;
        for (int k = 10; k <= 12; k++) begin
            req(32'h28001000, 32'(k));
            tick();
        end
        i_msi_ready = 1'b1;
        req(32'h28001000, 32'd13);
        tick();
        idle();
        i_msi_ready = 1'b0;
        check_msi("occ3_head", 6'd11, 2'b01, 2'd2);
        check("occ3_ready", 32'(o_req_ready), 32'd1);
        req(32'h28001000, 32'd14);
        tick();
        idle();
        check("occ4_ready", 32'(o_req_ready), 32'd0);
        i_msi_ready = 1'b1;
        for (int k = 11; k <= 14; k++) begin
            check_msi($sformatf("occ_drain%0d", k), 6'(k), 2'b01, 2'd2);
            tick();
        end
        check("occ_empty", 32'(o_msi_valid), 32'd0);

        // Reset with two entries buffered
        i_msi_ready = 1'b0;
        req(32'h24001000, 32'd20);
        tick();
        req(32'h24001000, 32'd21);
        tick();
        idle();
        check_msi("pre_rst_head", 6'd20, 2'b10, 2'd0);
        ni_rst = 1'b0;
        tick();
        check("mid_rst_vld",   32'(o_msi_valid), 32'd0);
        check("mid_rst_id",    32'(o_setipnum),  32'd0);
        check("mid_rst_drop",  32'(o_drop_cnt),  32'd0);
        check("mid_rst_ready", 32'(o_req_ready), 32'd0);
        ni_rst = 1'b1;
        i_msi_ready = 1'b1;
        tick();
        check("rel_vld",   32'(o_msi_valid), 32'd0);
        check("rel_ready", 32'(o_req_ready), 32'd1);
        tick();
        check("rel_vld2",  32'(o_msi_valid), 32'd0);
        check("rel_id",    32'(o_setipnum),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imsic_msi_decoder.md
Name: imsic_msi_decoder

Overview:
- Upstream stage of the IMSIC interrupt-file array.
- Accepts single-beat MSI write transactions from the system interconnect and decodes the target hart and interrupt file (M, S or VSn) from the address.
- Validates the identity carried in the data word, buffers accepted MSIs in a small FIFO, and presents one setipnum/imsic_en/select_file triple per cycle to the IMSIC.
- Replaces the APLIC channel when the IMSIC is driven by bus MSIs rather than an embedded APLIC.

Parameters:
- NrHarts, 2: number of harts; width of o_imsic_en.
- NrSources, 64: number of interrupt identities per file; valid identities are 1..NrSources-1.
- NrSourcesW, 6: width of the identity field, clog2(NrSources).
- NrVSInptFiles, 1: number of VS files per hart.
- NrInptFilesW, 2: width of the file select, clog2(NrVSInptFiles+2).
- InptFilesMAddr, 32'h24000000: base address of the M-level files.
- InptFilesSAddr, 32'h28000000: base address of the S/VS-level files.
- FifoDepth, 4: MSI buffer depth; must be a power of two and at least 2.

Ports:
- i_clk  in  1  clock.
- ni_rst  in  1  reset. Synchronous, active-low.
- i_req_valid  in  1  MSI write request valid.
- o_req_ready  out  1  request accepted when high together with i_req_valid.
- i_req_addr  in  32  write byte address.
- i_req_data  in  32  write data.
- o_msi_valid  out  1  decoded MSI valid.
- i_msi_ready  in  1  IMSIC consumes the MSI.
- o_setipnum  out  NrSourcesW  identity to set pending.
- o_imsic_en  out  NrHarts  one-hot target hart.
- o_select_file  out  NrInptFilesW  target file: 0=M, 1=S, 2+k=VS(k+1).
- o_drop_cnt  out  16  count of discarded requests; saturates.

Behaviour:
- Reset (ni_rst low at a rising edge):
  - FIFO is emptied; o_msi_valid=0, o_setipnum=0, o_imsic_en=0, o_select_file=0, o_drop_cnt=0, o_req_ready=0.
  - o_req_ready is 1 from the first cycle after reset is released.
  - A reset mid-operation discards all buffered MSIs. No partial output is produced.
- Handshake:
  - o_req_ready = FIFO not full. It is registered-free but depends only on state, not on i_req_valid.
  - Transfer occurs when i_req_valid & o_req_ready.
  - Output transfer occurs when o_msi_valid & i_msi_ready.
  - Output fields are held stable while o_msi_valid=1 and i_msi_ready=0.
- Address decode (4 KiB page per file, offset = addr[11:0]):
  - M window: addr in [InptFilesMAddr, InptFilesMAddr + NrHarts*0x1000). hart = (addr-InptFilesMAddr)>>12, file=0.
  - S window: addr in [InptFilesSAddr, InptFilesSAddr + NrHarts*(NrVSInptFiles+1)*0x1000).
    - page = (addr-InptFilesSAddr)>>12.
    - hart = page / (NrVSInptFiles+1); guest = page % (NrVSInptFiles+1).
    - file = 1 + guest.
    - When NrVSInptFiles+1 is a power of two, the divide reduces to a shift/mask. Otherwise it is a constant divide.
  - Offset 0x000 (seteipnum_le): identity = data.
  - Offset 0x004 (seteipnum_be): identity = byte-swapped data.
- Drop rules:
  - Any accepted request outside both windows, at another offset, or with identity 0 or identity ≥ NrSources is accepted (ready honoured) and discarded.
  - A discarded request is not pushed and increments o_drop_cnt by 1, saturating at 16'hFFFF.
  - The identity compare uses the full 32-bit value before truncation to NrSourcesW.
- Latency:
  - A valid request accepted in cycle N appears at the output with o_msi_valid=1 in cycle N+1 if the FIFO was empty. The FIFO head is registered.
  - Throughput is 1 MSI/cycle.
- FIFO:
  - First-in first-out order is preserved.
  - Push and pop in the same cycle leave occupancy unchanged, including at occupancy FifoDepth-1 and at 1.
  - Pointers wrap modulo FifoDepth.
  - When full, o_req_ready=0. A same-cycle pop does not raise ready until the next cycle.
- Duplicate MSIs (same hart/file/identity) are not merged. Each is forwarded.

Decomposition:
- imsic_pkg gains:
  - IMSIC_PAGE_W=12.
  - SETEIPNUM_LE_OFF='h000 and SETEIPNUM_BE_OFF='h004.
  - typedef struct packed imsic_msi_t {setipnum, imsic_en, select_file}, reusing the aplic_imsic_channel_t field widths.
- One sub-module, imsic_msi_fifo: a parameterised synchronous FIFO of imsic_msi_t with push/pop/full/empty and a registered head.

Test Plan:
- Write 0x24001000 data 5 → next cycle o_msi_valid=1, o_setipnum=5, o_imsic_en=2'b10, o_select_file=0.
- Write 0x28003004 data 32'h07000000 → setipnum=7, imsic_en=2'b10, select_file=2 (hart1 VS1, big-endian path).
- Writes with data 0, data 64, addr 0x24002000, and addr 0x28000008 → no o_msi_valid, o_drop_cnt=4.
- Hold i_msi_ready=0 and issue 5 back-to-back valid writes → 4 accepted, o_req_ready=0 on the 5th. Release ready → 4 MSIs drain in order, 1 per cycle, then the 5th is accepted.
- FIFO at occupancy 3: simultaneous push and pop → occupancy stays 3, order intact. Pull ni_rst low with 2 entries buffered → o_msi_valid=0 next cycle, o_drop_cnt=0, no stale output after release.
